hazard3_shift_arb: RTL

// Shares one combinational barrel shifter between two requesters (req0: ALU

---
 rtl/hazard3_shift_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hazard3_shift_arb.sv
// hazard3_shift_arb
//
// Round-robin arbiter that shares one combinational barrel shifter between two
// requesters. Requester 0 is the ALU shift path. Requester 1 is the
// bit-manipulation/funnel path. The winner's operands go out on sh_*. The
// shifter result comes back on sh_dout in the same cycle. That result is
// captured in a single registered response slot, tagged with the winner's ID.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready per-requester handshake (bit 0 = req0); ready is one-hot or 0
//   req_din         two W_DATA operands, req0 in the low half
//   req_shamt       two W_SHAMT shift amounts, req0 in the low field
//   req_ctrl        {arith,rotate,right_nleft} per requester, req0 in [2:0]
//   sh_*            operands to the external shifter, sh_dout = its result
//   rsp_valid/ready response slot handshake
//   rsp_id, rsp_data owner and registered result of the response slot

module hazard3_shift_arb #(
   parameter int W_DATA  = 32,
   parameter int W_SHAMT = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [2*W_DATA-1:0]  req_din,
   input  logic [2*W_SHAMT-1:0] req_shamt,
   input  logic [5:0]           req_ctrl,
   output logic [W_DATA-1:0]    sh_din,
   output logic [W_SHAMT-1:0]   sh_shamt,
   output logic                 sh_right_nleft,
   output logic                 sh_rotate,
   output logic                 sh_arith,
   input  logic [W_DATA-1:0]    sh_dout,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [W_DATA-1:0]    rsp_data
);

   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [W_DATA-1:0] rsp_data_q, rsp_data_d;
   logic              last_grant_q, last_grant_d;

   logic can_accept_s;
   logic grant_valid_s;
   logic grant_id_s;
   logic xfer_s;

   // Pick a winner: a lone requester wins outright, and under contention the
   // requester that did not win last time goes next.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
      case (req_valid)
         2'b01: begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
         end
         2'b10: begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
         end
         2'b11: begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_grant_q;
         end
         default: begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
         end
      endcase
      // Nothing is granted while reset is held, so ready and sh_* read 0.
      if (!rst_n) begin
         grant_valid_s = 1'b0;
         grant_id_s    = 1'b0;
      end else begin
         grant_valid_s = grant_valid_s;
         grant_id_s    = grant_id_s;
      end
   end

   // Accept handshake. The slot can take a new result when it is empty or
   // is being drained on this same edge.
   always_comb begin
      can_accept_s = !rsp_valid_q || rsp_ready;
      req_ready    = 2'b00;
      if (grant_valid_s && can_accept_s) begin
         if (grant_id_s) begin
            req_ready = 2'b10;
         end else begin
            req_ready = 2'b01;
         end
      end else begin
         req_ready = 2'b00;
      end
      xfer_s = |(req_valid & req_ready);
   end

   // Steer the granted requester's operands to the shifter. This does not
   // wait for can_accept, so the shifter inputs do not depend on rsp_ready.
   always_comb begin
      sh_din         = {W_DATA{1'b0}};
      sh_shamt       = {W_SHAMT{1'b0}};
      sh_right_nleft = 1'b0;
      sh_rotate      = 1'b0;
      sh_arith       = 1'b0;
      if (grant_valid_s) begin
         if (grant_id_s) begin
            sh_din         = req_din[2*W_DATA-1:W_DATA];
            sh_shamt       = req_shamt[2*W_SHAMT-1:W_SHAMT];
            sh_right_nleft = req_ctrl[3];
            sh_rotate      = req_ctrl[4];
            sh_arith       = req_ctrl[5];
         end else begin
            sh_din         = req_din[W_DATA-1:0];
            sh_shamt       = req_shamt[W_SHAMT-1:0];
            sh_right_nleft = req_ctrl[0];
            sh_rotate      = req_ctrl[1];
            sh_arith       = req_ctrl[2];
         end
      end else begin
         sh_din         = {W_DATA{1'b0}};
         sh_shamt       = {W_SHAMT{1'b0}};
         sh_right_nleft = 1'b0;
         sh_rotate      = 1'b0;
         sh_arith       = 1'b0;
      end
   end

   // Response slot and round-robin pointer next state. A new result
   // overwrites a draining one on the same edge. A drain with no new result
   // clears only the valid bit.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      last_grant_d = last_grant_q;
      if (xfer_s) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant_id_s;
         rsp_data_d   = sh_dout;
         last_grant_d = grant_id_s;
      end else if (rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end else begin
         rsp_valid_d  = rsp_valid_q;
      end
   end

   // State registers. last_grant resets to 1 so req0 wins the first
   // contended cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= {W_DATA{1'b0}};
         last_grant_q <= 1'b1;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

endmodule
